// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage consumer of the EX/MEM pipeline register.
// It turns EX/MEM load/store controls into a req/ack transaction on a
// variable-latency data memory. While a transaction is outstanding it stalls
// the upstream pipeline. It also registers a MEM/WB-ready bundle and a
// one-cycle error pulse.
//
// Ports:
//   clk_i, rst_i              clock (rising edge), async active-high reset
//   REG_WRITE, MEM_TO_REG     EX/MEM write-back controls
//   MEMREAD, MEMWRITE         EX/MEM load / store request
//   ALU_RESULT, WRITE_DATA    EX/MEM address/ALU value and store data
//   RD                        EX/MEM destination register
//   MEM_ACK, MEM_RDATA        data memory strobe and read data
//   MEM_REQ_O, MEM_WE_O       memory request and write enable
//   MEM_ADDR_O, MEM_WDATA_O   memory address and store data
//   STALL_O                   combinational upstream hold
//   REG_WRITE_O, MEM_TO_REG_O, READ_DATA_O, ALU_RESULT_O, RD_O, ERR_O
//                             MEM/WB bundle
module mem_access_unit #(
  parameter int unsigned MAX_WAIT = 15,
  parameter int unsigned WAIT_W   = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        REG_WRITE,
  input  logic        MEM_TO_REG,
  input  logic        MEMREAD,
  input  logic        MEMWRITE,
  input  logic [31:0] ALU_RESULT,
  input  logic [31:0] WRITE_DATA,
  input  logic [4:0]  RD,
  input  logic        MEM_ACK,
  input  logic [31:0] MEM_RDATA,
  output logic        MEM_REQ_O,
  output logic        MEM_WE_O,
  output logic [31:0] MEM_ADDR_O,
  output logic [31:0] MEM_WDATA_O,
  output logic        STALL_O,
  output logic        REG_WRITE_O,
  output logic        MEM_TO_REG_O,
  output logic [31:0] READ_DATA_O,
  output logic [31:0] ALU_RESULT_O,
  output logic [4:0]  RD_O,
  output logic        ERR_O
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] cnt;
  logic [31:0]       cap_data;
  logic              abort;
  logic              access, bad, start, timeout;

  assign access  = MEMREAD ^ MEMWRITE;
  assign bad     = (MEMREAD & MEMWRITE) |
                   ((MEMREAD | MEMWRITE) & (ALU_RESULT[1:0] != 2'b00));
  assign start   = access & ~bad;
  assign timeout = (cnt == WAIT_W'(MAX_WAIT - 1));

  always_comb begin
    state_nxt = state;
    STALL_O   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          STALL_O   = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        STALL_O = 1'b1;
        if (MEM_ACK || timeout) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (rst_i) STALL_O = 1'b0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  // Memory-side transaction registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      MEM_REQ_O   <= 1'b0;
      MEM_WE_O    <= 1'b0;
      MEM_ADDR_O  <= '0;
      MEM_WDATA_O <= '0;
      cnt         <= '0;
      cap_data    <= '0;
      abort       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            MEM_REQ_O   <= 1'b1;
            MEM_WE_O    <= MEMWRITE;
            MEM_ADDR_O  <= ALU_RESULT;
            MEM_WDATA_O <= WRITE_DATA;
            cnt         <= '0;
            cap_data    <= '0;
            abort       <= 1'b0;
          end
        end
        BUSY: begin
          // Ack is checked first so it wins over a same-cycle timeout.
          if (MEM_ACK) begin
            MEM_REQ_O <= 1'b0;
            if (!MEM_WE_O) cap_data <= MEM_RDATA;
          end else if (timeout) begin
            MEM_REQ_O <= 1'b0;
            abort     <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // MEM/WB bundle
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      REG_WRITE_O  <= 1'b0;
      MEM_TO_REG_O <= 1'b0;
      READ_DATA_O  <= '0;
      ALU_RESULT_O <= '0;
      RD_O         <= '0;
      ERR_O        <= 1'b0;
    end else if (STALL_O) begin
      REG_WRITE_O  <= 1'b0;
      MEM_TO_REG_O <= 1'b0;
      ERR_O        <= 1'b0;
    end else if (state == DONE) begin
      REG_WRITE_O  <= REG_WRITE & ~abort;
      MEM_TO_REG_O <= MEM_TO_REG;
      READ_DATA_O  <= cap_data;
      ALU_RESULT_O <= ALU_RESULT;
      RD_O         <= RD;
      ERR_O        <= abort;
    end else begin
      REG_WRITE_O  <= REG_WRITE & ~bad;
      MEM_TO_REG_O <= MEM_TO_REG;
      READ_DATA_O  <= '0;
      ALU_RESULT_O <= ALU_RESULT;
      RD_O         <= RD;
      ERR_O        <= bad;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        REG_WRITE, MEM_TO_REG, MEMREAD, MEMWRITE;
  logic [31:0] ALU_RESULT, WRITE_DATA;
  logic [4:0]  RD;
  logic        MEM_ACK;
  logic [31:0] MEM_RDATA;
  logic        MEM_REQ_O, MEM_WE_O;
  logic [31:0] MEM_ADDR_O, MEM_WDATA_O;
  logic        STALL_O, REG_WRITE_O, MEM_TO_REG_O;
  logic [31:0] READ_DATA_O, ALU_RESULT_O;
  logic [4:0]  RD_O;
  logic        ERR_O;

  int n_chk  = 0;
  int n_fail = 0;
  int stall_cnt;

  always #5 clk_i = ~clk_i;

  mem_access_unit #(.MAX_WAIT(4), .WAIT_W(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .REG_WRITE(REG_WRITE), .MEM_TO_REG(MEM_TO_REG),
    .MEMREAD(MEMREAD), .MEMWRITE(MEMWRITE),
    .ALU_RESULT(ALU_RESULT), .WRITE_DATA(WRITE_DATA), .RD(RD),
    .MEM_ACK(MEM_ACK), .MEM_RDATA(MEM_RDATA),
    .MEM_REQ_O(MEM_REQ_O), .MEM_WE_O(MEM_WE_O),
    .MEM_ADDR_O(MEM_ADDR_O), .MEM_WDATA_O(MEM_WDATA_O),
    .STALL_O(STALL_O), .REG_WRITE_O(REG_WRITE_O), .MEM_TO_REG_O(MEM_TO_REG_O),
    .READ_DATA_O(READ_DATA_O), .ALU_RESULT_O(ALU_RESULT_O),
    .RD_O(RD_O), .ERR_O(ERR_O)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic nop();
    REG_WRITE = 0; MEM_TO_REG = 0; MEMREAD = 0; MEMWRITE = 0;
    ALU_RESULT = '0; WRITE_DATA = '0; RD = '0;
  endtask

  task automatic set_load(input logic [31:0] addr, input logic [4:0] rd);
    REG_WRITE = 1; MEM_TO_REG = 1; MEMREAD = 1; MEMWRITE = 0;
    ALU_RESULT = addr; WRITE_DATA = '0; RD = rd;
  endtask

  initial begin
    nop();
    MEM_ACK = 0; MEM_RDATA = '0;
    rst_i = 1;
    #12;
    chk("rst_req", {31'b0, MEM_REQ_O}, 0);
    chk("rst_stall", {31'b0, STALL_O}, 0);
    chk("rst_rw", {31'b0, REG_WRITE_O}, 0);
    chk("rst_err", {31'b0, ERR_O}, 0);
    rst_i = 0;
    step();

    // ALU op passes through in one edge
    REG_WRITE = 1; RD = 5; ALU_RESULT = 32'h1234;
    #1 chk("alu_stall", {31'b0, STALL_O}, 0);
    step();
    chk("alu_rw", {31'b0, REG_WRITE_O}, 1);
    chk("alu_rd", {27'b0, RD_O}, 5);
    chk("alu_res", ALU_RESULT_O, 32'h1234);
    chk("alu_err", {31'b0, ERR_O}, 0);
    chk("alu_stall2", {31'b0, STALL_O}, 0);
    nop();
    // ack while IDLE is ignored
    MEM_ACK = 1;
    step();
    chk("idle_ack_req", {31'b0, MEM_REQ_O}, 0);
    chk("idle_ack_stall", {31'b0, STALL_O}, 0);
    MEM_ACK = 0;

    // Load at 0x40, ack in 3rd BUSY cycle
    set_load(32'h40, 5'd7);
    stall_cnt = 0;
    #1 chk("ld_stall0", {31'b0, STALL_O}, 1);
    chk("ld_req0", {31'b0, MEM_REQ_O}, 0);
    if (STALL_O) stall_cnt++;
    for (int i = 0; i < 3; i++) begin
      step();
      if (i == 2) begin MEM_ACK = 1; MEM_RDATA = 32'hDEADBEEF; end
      #1;
      if (STALL_O) stall_cnt++;
      chk("ld_busy_req", {31'b0, MEM_REQ_O}, 1);
      chk("ld_busy_addr", MEM_ADDR_O, 32'h40);
      chk("ld_busy_we", {31'b0, MEM_WE_O}, 0);
      chk("ld_bubble_rw", {31'b0, REG_WRITE_O}, 0);
    end
    step();
    MEM_ACK = 0; MEM_RDATA = '0;
    #1;
    if (STALL_O) stall_cnt++;
    chk("ld_done_req", {31'b0, MEM_REQ_O}, 0);
    chk("ld_stall_cycles", stall_cnt, 4);
    step();
    chk("ld_data", READ_DATA_O, 32'hDEADBEEF);
    chk("ld_rw", {31'b0, REG_WRITE_O}, 1);
    chk("ld_m2r", {31'b0, MEM_TO_REG_O}, 1);
    chk("ld_rd", {27'b0, RD_O}, 7);
    chk("ld_err", {31'b0, ERR_O}, 0);
    nop();

    // Store at 0x44, immediate ack
    MEMWRITE = 1; ALU_RESULT = 32'h44; WRITE_DATA = 32'hA5A5A5A5; RD = 3;
    step();
    chk("st_req", {31'b0, MEM_REQ_O}, 1);
    chk("st_we", {31'b0, MEM_WE_O}, 1);
    chk("st_wdata", MEM_WDATA_O, 32'hA5A5A5A5);
    chk("st_addr", MEM_ADDR_O, 32'h44);
    MEM_ACK = 1; MEM_RDATA = 32'h55555555;
    step();
    MEM_ACK = 0;
    #1 chk("st_one_ack", {31'b0, MEM_REQ_O}, 0);
    chk("st_done_stall", {31'b0, STALL_O}, 0);
    step();
    chk("st_rw", {31'b0, REG_WRITE_O}, 0);
    chk("st_data", READ_DATA_O, 0);
    chk("st_err", {31'b0, ERR_O}, 0);
    nop();

    // Misaligned load
    set_load(32'h42, 5'd9);
    #1 chk("mis_stall", {31'b0, STALL_O}, 0);
    step();
    chk("mis_req", {31'b0, MEM_REQ_O}, 0);
    chk("mis_err", {31'b0, ERR_O}, 1);
    chk("mis_rw", {31'b0, REG_WRITE_O}, 0);
    nop();
    step();
    chk("mis_err_pulse", {31'b0, ERR_O}, 0);

    // Read and write together
    set_load(32'h40, 5'd9);
    MEMWRITE = 1;
    #1 chk("rw_stall", {31'b0, STALL_O}, 0);
    step();
    chk("rw_req", {31'b0, MEM_REQ_O}, 0);
    chk("rw_err", {31'b0, ERR_O}, 1);
    chk("rw_rw", {31'b0, REG_WRITE_O}, 0);
    nop();
    step();
    chk("rw_err_pulse", {31'b0, ERR_O}, 0);

    // Timeout: no ack for MAX_WAIT=4 BUSY cycles
    set_load(32'h80, 5'd2);
    step();
    for (int i = 0; i < 4; i++) begin
      chk("to_busy_req", {31'b0, MEM_REQ_O}, 1);
      chk("to_busy_stall", {31'b0, STALL_O}, 1);
      step();
    end
    chk("to_done_req", {31'b0, MEM_REQ_O}, 0);
    chk("to_done_stall", {31'b0, STALL_O}, 0);
    step();
    chk("to_err", {31'b0, ERR_O}, 1);
    chk("to_rw", {31'b0, REG_WRITE_O}, 0);
    nop();
    step();
    chk("to_err_pulse", {31'b0, ERR_O}, 0);

    // Ack in the 4th BUSY cycle wins over timeout
    set_load(32'h84, 5'd4);
    step();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin MEM_ACK = 1; MEM_RDATA = 32'h12345678; end
      chk("aw_busy_req", {31'b0, MEM_REQ_O}, 1);
      step();
    end
    MEM_ACK = 0; MEM_RDATA = '0;
    chk("aw_done_req", {31'b0, MEM_REQ_O}, 0);
    step();
    chk("aw_data", READ_DATA_O, 32'h12345678);
    chk("aw_err", {31'b0, ERR_O}, 0);
    chk("aw_rw", {31'b0, REG_WRITE_O}, 1);
    nop();
    step();

    // Reset in the middle of BUSY
    set_load(32'h100, 5'd6);
    step();
    chk("rb_req", {31'b0, MEM_REQ_O}, 1);
    rst_i = 1;
    #1;
    chk("rb_req0", {31'b0, MEM_REQ_O}, 0);
    chk("rb_stall0", {31'b0, STALL_O}, 0);
    chk("rb_addr0", MEM_ADDR_O, 0);
    chk("rb_rd0", {27'b0, RD_O}, 0);
    chk("rb_alu0", ALU_RESULT_O, 0);
    chk("rb_data0", READ_DATA_O, 0);
    rst_i = 0;
    set_load(32'h200, 5'd8);
    #1 chk("rb_new_stall", {31'b0, STALL_O}, 1);
    step();
    chk("rb_new_req", {31'b0, MEM_REQ_O}, 1);
    chk("rb_new_addr", MEM_ADDR_O, 32'h200);
    MEM_ACK = 1; MEM_RDATA = 32'hCAFEF00D;
    step();
    MEM_ACK = 0;
    step();
    chk("rb_new_data", READ_DATA_O, 32'hCAFEF00D);
    chk("rb_new_rw", {31'b0, REG_WRITE_O}, 1);
    chk("rb_new_rd", {27'b0, RD_O}, 8);
    nop();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
